// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB, handshakes with the shared memory port,
// drives datapath enables/muxes, counts retired instructions and traps
// illegal opcodes into an absorbing HALT state.
module mc_ctrl_fsm #(
  parameter int         CNT_W      = 32,
  parameter logic [1:0] RST_PC_SEL = 2'd0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             mem_sel_o,
  input  logic             mem_ack_i,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic [1:0]       pc_src_o,
  output logic [1:0]       ext_mode_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             illegal_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  state_t           state, nxt;
  logic [5:0]       op_q, fn_q;
  logic [5:0]       op;
  logic             illegal_q, set_illegal, retire;
  logic [CNT_W-1:0] cnt_q;

  // funct is decoded by the ALU control; the latched copy is kept for debug.
  logic unused_funct;
  assign unused_funct = ^fn_q;

  // In DECODE the IR output is live; afterwards use the latched copy so the
  // IR bus may change without disturbing the sequence.
  assign op = (state == S_DECODE) ? opcode_i : op_q;

  logic is_r, is_j, is_beq, is_bne, is_lw, is_sw, is_addi, is_ilog, legal;
  assign is_r    = (op == OP_R);
  assign is_j    = (op == OP_J);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_addi = (op == OP_ADDI);
  assign is_ilog = (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_LUI);
  assign legal   = is_r || is_j || is_beq || is_bne || is_lw || is_sw || is_addi || is_ilog;

  // State, latched opcode/funct, sticky illegal flag and retire counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_FETCH;
      op_q      <= '0;
      fn_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) begin
        op_q <= opcode_i;
        fn_q <= funct_i;
      end
      if (set_illegal) illegal_q <= 1'b1;
      if (retire)      cnt_q     <= cnt_q + CNT_W'(1);
    end
  end

  // Next-state and per-state datapath controls; reset forces quiet outputs.
  always_comb begin
    nxt          = state;
    retire       = 1'b0;
    set_illegal  = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_sel_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 2'd0;
    ext_mode_o   = 2'd0;
    alu_src_b_o  = 2'd0;
    alu_op_o     = 2'd0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;

    if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      if (op == OP_ANDI || op == OP_ORI) ext_mode_o = 2'd1;
      else if (op == OP_LUI)             ext_mode_o = 2'd2;
    end

    case (state)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'd1;
        if (mem_ack_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          nxt        = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b_o = 2'd3;
        if (is_j) begin
          pc_write_o = 1'b1;
          pc_src_o   = 2'd2;
          retire     = 1'b1;
          nxt        = S_FETCH;
        end else if (!legal) begin
          set_illegal = 1'b1;
          nxt         = S_HALT;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        nxt = S_WB;
        if (is_r) begin
          alu_op_o = 2'd2;
        end else if (is_beq || is_bne) begin
          alu_op_o   = 2'd1;
          pc_src_o   = 2'd1;
          pc_write_o = (is_beq & zero_i) | (is_bne & ~zero_i);
          retire     = 1'b1;
          nxt        = S_FETCH;
        end else if (is_ilog) begin
          alu_src_b_o = 2'd2;
          alu_op_o    = 2'd3;
        end else begin
          alu_src_b_o = 2'd2;
          if (is_lw || is_sw) nxt = S_MEM;
        end
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        mem_sel_o = 1'b1;
        mem_we_o  = is_sw;
        if (mem_ack_i) begin
          if (is_sw) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = is_r;
        mem_to_reg_o = is_lw;
        retire       = 1'b1;
        nxt          = S_FETCH;
      end
      default: nxt = S_HALT;
    endcase

    // Reset drops every strobe immediately, even mid-transaction.
    if (!rst_i) begin
      retire       = 1'b0;
      set_illegal  = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_sel_o    = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      pc_src_o     = RST_PC_SEL;
      ext_mode_o   = 2'd0;
      alu_src_b_o  = 2'd0;
      alu_op_o     = 2'd0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_write_o  = 1'b0;
    end
  end

  assign illegal_o   = illegal_q;
  assign state_o     = state;
  assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm (CNT_W=4 to reach the wrap).
module tb_mc_ctrl_fsm;
  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [5:0]       opcode_i, funct_i;
  logic             zero_i, mem_ack_i;
  logic             mem_req_o, mem_we_o, mem_sel_o, ir_write_o, pc_write_o;
  logic [1:0]       pc_src_o, ext_mode_o, alu_src_b_o, alu_op_o;
  logic             reg_dst_o, mem_to_reg_o, reg_write_o, illegal_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] instr_cnt_o;

  int checks = 0;
  int errors = 0;

  mc_ctrl_fsm #(.CNT_W(CNT_W), .RST_PC_SEL(2'd2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i),
    .zero_i(zero_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_sel_o(mem_sel_o), .mem_ack_i(mem_ack_i), .ir_write_o(ir_write_o),
    .pc_write_o(pc_write_o), .pc_src_o(pc_src_o), .ext_mode_o(ext_mode_o),
    .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .illegal_o(illegal_o), .state_o(state_o), .instr_cnt_o(instr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // One zero-wait FETCH cycle; leaves the DUT in DECODE.
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
    opcode_i  = op;
    funct_i   = fn;
    mem_ack_i = 1'b1;
    #1;
    chk("fetch_state", state_o, 0);
    chk("fetch_req", mem_req_o, 1);
    chk("fetch_irw", ir_write_o, 1);
    cyc();
    mem_ack_i = 1'b0;
  endtask

  // Branch in EXEC: expected pc_write given.
  task automatic branch(input logic [5:0] op, input logic z, input logic exp_pw,
                        input logic [CNT_W-1:0] exp_cnt);
    fetch(op, 6'h00);
    chk("br_dec_state", state_o, 1);
    cyc();
    zero_i = z;
    #1;
    chk("br_exec_state", state_o, 2);
    chk("br_alu_op", alu_op_o, 1);
    chk("br_pc_src", pc_src_o, 1);
    chk("br_pc_write", pc_write_o, exp_pw);
    cyc();
    zero_i = 1'b0;
    chk("br_back_fetch", state_o, 0);
    chk("br_cnt", instr_cnt_o, exp_cnt);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic req_seen;
    rst_i = 1'b0; opcode_i = '0; funct_i = '0; zero_i = 1'b0; mem_ack_i = 1'b0;
    #12;
    chk("rst_state", state_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_pc_src", pc_src_o, 2);
    chk("rst_alu_b", alu_src_b_o, 0);
    chk("rst_cnt", instr_cnt_o, 0);
    chk("rst_illegal", illegal_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("fetch_alu_b", alu_src_b_o, 1);

    // R-type add: 0,1,2,4,0
    fetch(6'h00, 6'h20);
    chk("r_dec_state", state_o, 1);
    chk("r_dec_alu_b", alu_src_b_o, 3);
    chk("r_dec_regw", reg_write_o, 0);
    cyc();
    chk("r_exec_state", state_o, 2);
    chk("r_exec_alu_op", alu_op_o, 2);
    chk("r_exec_alu_b", alu_src_b_o, 0);
    chk("r_exec_regw", reg_write_o, 0);
    cyc();
    chk("r_wb_state", state_o, 4);
    chk("r_wb_regw", reg_write_o, 1);
    chk("r_wb_regdst", reg_dst_o, 1);
    cyc();
    chk("r_cnt", instr_cnt_o, 1);
    chk("r_regw_off", reg_write_o, 0);

    // ori: zero-extend held DECODE..WB
    fetch(6'h0D, 6'h00);
    chk("ori_dec_ext", ext_mode_o, 1);
    cyc();
    chk("ori_exec_ext", ext_mode_o, 1);
    chk("ori_exec_alu_b", alu_src_b_o, 2);
    chk("ori_exec_alu_op", alu_op_o, 3);
    cyc();
    chk("ori_wb_ext", ext_mode_o, 1);
    chk("ori_wb_regdst", reg_dst_o, 0);
    cyc();
    chk("ori_cnt", instr_cnt_o, 2);

    // lui: imm<<16
    fetch(6'h0F, 6'h00);
    chk("lui_dec_ext", ext_mode_o, 2);
    cyc();
    chk("lui_exec_ext", ext_mode_o, 2);
    chk("lui_exec_alu_b", alu_src_b_o, 2);
    cyc();
    chk("lui_wb_ext", ext_mode_o, 2);
    cyc();

    // addi: sign-extend, add
    fetch(6'h08, 6'h00);
    chk("addi_dec_ext", ext_mode_o, 0);
    cyc();
    chk("addi_exec_alu_b", alu_src_b_o, 2);
    chk("addi_exec_alu_op", alu_op_o, 0);
    cyc();
    chk("addi_wb_state", state_o, 4);
    cyc();
    chk("addi_cnt", instr_cnt_o, 4);

    // lw with 3-cycle MEM wait; IR bus changes after DECODE to prove latching
    fetch(6'h23, 6'h00);
    cyc();
    opcode_i = 6'h2B;
    #1;
    chk("lw_exec_state", state_o, 2);
    cyc();
    for (int i = 0; i < 3; i++) begin
      mem_ack_i = (i == 2);
      #1;
      chk("lw_mem_state", state_o, 3);
      chk("lw_mem_req", mem_req_o, 1);
      chk("lw_mem_sel", mem_sel_o, 1);
      chk("lw_mem_we", mem_we_o, 0);
      cyc();
    end
    mem_ack_i = 1'b0;
    chk("lw_wb_state", state_o, 4);
    chk("lw_wb_m2r", mem_to_reg_o, 1);
    chk("lw_wb_regdst", reg_dst_o, 0);
    cyc();
    chk("lw_cnt", instr_cnt_o, 5);

    // sw zero-wait: 4 cycles, write
    fetch(6'h2B, 6'h00);
    cyc();
    cyc();
    mem_ack_i = 1'b1;
    #1;
    chk("sw_mem_we", mem_we_o, 1);
    chk("sw_mem_sel", mem_sel_o, 1);
    cyc();
    mem_ack_i = 1'b0;
    chk("sw_back_fetch", state_o, 0);
    chk("sw_cnt", instr_cnt_o, 6);

    branch(6'h04, 1'b1, 1'b1, 4'd7);
    branch(6'h04, 1'b0, 1'b0, 4'd8);
    branch(6'h05, 1'b1, 1'b0, 4'd9);
    branch(6'h05, 1'b0, 1'b1, 4'd10);

    // j: 2 cycles
    fetch(6'h02, 6'h00);
    chk("j_pc_write", pc_write_o, 1);
    chk("j_pc_src", pc_src_o, 2);
    cyc();
    chk("j_state", state_o, 0);
    chk("j_cnt", instr_cnt_o, 11);

    // illegal opcode -> HALT, quiet for 20 cycles despite acks
    fetch(6'h3F, 6'h00);
    chk("ill_dec_state", state_o, 1);
    cyc();
    chk("ill_state", state_o, 5);
    chk("ill_flag", illegal_o, 1);
    req_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mem_ack_i = i[0];
      #1;
      if (mem_req_o || state_o != 3'd5) req_seen = 1'b1;
      cyc();
    end
    mem_ack_i = 1'b0;
    chk("halt_quiet", req_seen, 0);
    chk("halt_cnt", instr_cnt_o, 11);
    rst_i = 1'b0;
    cyc();
    chk("ill_rst_flag", illegal_o, 0);
    chk("ill_rst_state", state_o, 0);
    chk("ill_rst_cnt", instr_cnt_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;

    // 15 jumps reach all-ones, the 16th wraps
    for (int i = 0; i < 15; i++) begin
      fetch(6'h02, 6'h00);
      cyc();
    end
    chk("cnt_max", instr_cnt_o, 15);
    fetch(6'h02, 6'h00);
    cyc();
    chk("cnt_wrap", instr_cnt_o, 0);
    fetch(6'h02, 6'h00);
    cyc();
    chk("cnt_after_wrap", instr_cnt_o, 1);

    // reset asserted mid-MEM, between clock edges
    fetch(6'h2B, 6'h00);
    cyc();
    cyc();
    chk("mid_mem_state", state_o, 3);
    chk("mid_mem_req", mem_req_o, 1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_req_drop", mem_req_o, 0);
    chk("async_cnt_clr", instr_cnt_o, 0);
    chk("async_state", state_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
